// File: rtl/wb_regfile_sb_if.sv
// Writeback-side and ID-side bus of the scoreboarded register file.
interface wb_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            wb_reg_write;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_rd_data;
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic [XLEN-1:0] id_rs_data;
    logic [XLEN-1:0] id_rt_data;
    logic            id_issue;
    logic [AW-1:0]   id_issue_rd;
    logic            id_stall;
    logic            sb_ovf;
    logic            sb_unf;

    modport slave (
        input  wb_reg_write, wb_rd, wb_rd_data, id_rs, id_rt, id_issue, id_issue_rd,
        output id_rs_data, id_rt_data, id_stall, sb_ovf, sb_unf
    );

    modport master (
        output wb_reg_write, wb_rd, wb_rd_data, id_rs, id_rt, id_issue, id_issue_rd,
        input  id_rs_data, id_rt_data, id_stall, sb_ovf, sb_unf
    );
endinterface

// File: rtl/wb_regfile_sb.sv
// 32x32 register file written from WB with a per-register in-flight writer scoreboard.
// Define WB_REGFILE_BYPASS_EN to forward the retiring WB value to the ID read ports.
module wb_regfile_sb #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int SBW  = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    wb_regfile_sb_if.slave bus
);
    localparam int             AW      = $clog2(NREG);
    localparam logic [SBW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] regs [NREG];
    logic [SBW-1:0]  cnt  [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            acc;
    logic            ret;
    logic            stall;
    logic            ovf;
    logic            unf;

    assign ret = bus.wb_reg_write && (bus.wb_rd != '0);
    assign acc = bus.id_issue && !stall && (bus.id_issue_rd != '0);

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
`ifdef WB_REGFILE_BYPASS_EN
            // The last outstanding writer retiring now is forwarded, so no hold.
            if (ret && (bus.wb_rd == AW'(r)) && (cnt[r] == SBW'(1)))
                busy[r] = 1'b0;
`endif
        end
    end

    assign stall = busy[bus.id_rs] | busy[bus.id_rt];

    always_comb begin
        rs_data = (bus.id_rs == '0) ? '0 : regs[bus.id_rs];
        rt_data = (bus.id_rt == '0) ? '0 : regs[bus.id_rt];
`ifdef WB_REGFILE_BYPASS_EN
        if (ret && (bus.wb_rd == bus.id_rs))
            rs_data = bus.wb_rd_data;
        if (ret && (bus.wb_rd == bus.id_rt))
            rt_data = bus.wb_rd_data;
`endif
    end

    always_comb begin
        inc = '0;
        dec = '0;
        if (acc)
            inc[bus.id_issue_rd] = 1'b1;
        if (ret)
            dec[bus.wb_rd] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ret)
                regs[bus.wb_rd] <= bus.wb_rd_data;
            // Issue and retire on the same register cancel out.
            for (int r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r]) begin
                    if (cnt[r] == CNT_MAX)
                        ovf <= 1'b1;
                    else
                        cnt[r] <= cnt[r] + 1'b1;
                end else if (dec[r] && !inc[r]) begin
                    if (cnt[r] == '0)
                        unf <= 1'b1;
                    else
                        cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    assign bus.id_rs_data = rs_data;
    assign bus.id_rt_data = rt_data;
    assign bus.id_stall   = stall;
    assign bus.sb_ovf     = ovf;
    assign bus.sb_unf     = unf;
endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed and randomized bench for wb_regfile_sb against a behavioural register/scoreboard model.
module tb_wb_regfile_sb;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_ovf;
    bit          m_unf;

    wb_regfile_sb_if bus ();

    wb_regfile_sb dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic bit m_ret();
        return bus.wb_reg_write && (bus.wb_rd != 0);
    endfunction

    function automatic bit m_busy(int r);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
        if (BYP && m_ret() && int'(bus.wb_rd) == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return m_busy(int'(bus.id_rs)) || m_busy(int'(bus.id_rt));
    endfunction

    function automatic logic [31:0] m_read(int idx);
        if (idx == 0) return 32'd0;
        if (BYP && m_ret() && int'(bus.wb_rd) == idx) return bus.wb_rd_data;
        return m_reg[idx];
    endfunction

    // Applies one clock edge of the specified behaviour to the model.
    task automatic m_update();
        bit acc;
        bit ret;
        int ir;
        int wr;
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r] = 32'd0;
                m_cnt[r] = 0;
            end
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        acc = bus.id_issue && !m_stall() && (bus.id_issue_rd != 0);
        ret = m_ret();
        ir  = int'(bus.id_issue_rd);
        wr  = int'(bus.wb_rd);
        if (ret) m_reg[wr] = bus.wb_rd_data;
        if (acc && ret && ir == wr) return;
        if (acc) begin
            if (m_cnt[ir] == 3) m_ovf = 1'b1;
            else m_cnt[ir] = m_cnt[ir] + 1;
        end
        if (ret) begin
            if (m_cnt[wr] == 0) m_unf = 1'b1;
            else m_cnt[wr] = m_cnt[wr] - 1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        #1;
        chk({tag, ".rs"},    bus.id_rs_data, m_read(int'(bus.id_rs)));
        chk({tag, ".rt"},    bus.id_rt_data, m_read(int'(bus.id_rt)));
        chk({tag, ".stall"}, 32'(bus.id_stall), 32'(m_stall()));
        chk({tag, ".ovf"},   32'(bus.sb_ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(bus.sb_unf), 32'(m_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        bus.wb_reg_write = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_rd_data   = '0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_issue     = 1'b0;
        bus.id_issue_rd  = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wb(logic [4:0] rd, logic [31:0] d);
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = rd;
        bus.wb_rd_data   = d;
    endtask

    task automatic issue(logic [4:0] rd);
        bus.id_issue    = 1'b1;
        bus.id_issue_rd = rd;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = 32'd0;
            m_cnt[r] = 0;
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
        idle();
        reset = 1'b0;

        // Reset with a pending write on the bus
        wb(5'd5, 32'hFFFF);
        tick();
        tick();
        reset = 1'b1;
        idle();
        bus.id_rs = 5'd5;
        #1;
        chk("rst_rd5", bus.id_rs_data, 32'd0);
        chk("rst_stall", 32'(bus.id_stall), 32'd0);
        chk("rst_ovf", 32'(bus.sb_ovf), 32'd0);
        chk("rst_unf", 32'(bus.sb_unf), 32'd0);
        check_all("rst");

        // Write/read and $0
        wb(5'd10, 32'd2);
        bus.id_rs = 5'd10;
        #1;
        chk("wr_same_cycle", bus.id_rs_data, BYP ? 32'd2 : 32'd0);
        tick();
        wb(5'd0, 32'd7);
        bus.id_rs = 5'd10;
        bus.id_rt = 5'd0;
        #1;
        chk("wr_r10", bus.id_rs_data, 32'd2);
        chk("wr_r0_byp", bus.id_rt_data, 32'd0);
        tick();
        idle();
        bus.id_rt = 5'd0;
        #1;
        chk("wr_r0", bus.id_rt_data, 32'd0);
        check_all("wr");

        // RAW stall resolved at WB
        do_reset();
        issue(5'd10);
        tick();
        idle();
        bus.id_rs = 5'd10;
        #1;
        chk("raw_stall1", 32'(bus.id_stall), 32'd1);
        tick();
        #1;
        chk("raw_stall2", 32'(bus.id_stall), 32'd1);
        wb(5'd10, 32'h1234);
        #1;
        chk("raw_wb_stall", 32'(bus.id_stall), BYP ? 32'd0 : 32'd1);
        if (BYP) chk("raw_wb_data", bus.id_rs_data, 32'h1234);
        check_all("raw_wb");
        tick();
        idle();
        bus.id_rs = 5'd10;
        #1;
        chk("raw_after_stall", 32'(bus.id_stall), 32'd0);
        chk("raw_after_data", bus.id_rs_data, 32'h1234);

        // Simultaneous issue and retire, then issue while stalled
        do_reset();
        issue(5'd8);
        tick();
        issue(5'd8);
        wb(5'd8, 32'hA5A5);
        check_all("sim_both");
        tick();
        idle();
        bus.id_rs = 5'd8;
        #1;
        chk("sim_stall", 32'(bus.id_stall), 32'd1);
        chk("sim_unf", 32'(bus.sb_unf), 32'd0);
        issue(5'd9);
        tick();
        idle();
        bus.id_rs = 5'd9;
        #1;
        chk("stalled_issue_ignored", 32'(bus.id_stall), 32'd0);
        bus.id_rs = 5'd8;
        #1;
        chk("sim_still_busy", 32'(bus.id_stall), 32'd1);

        // Saturation and underflow on r3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(5'd3);
            #1;
            chk("sat_ovf_pre", 32'(bus.sb_ovf), 32'd0);
            tick();
        end
        idle();
        bus.id_rs = 5'd3;
        #1;
        chk("sat_ovf", 32'(bus.sb_ovf), 32'd1);
        chk("sat_stall", 32'(bus.id_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wb(5'd3, 32'(i + 100));
            #1;
            chk("sat_ret_stall", 32'(bus.id_stall), (i == 2 && BYP) ? 32'd0 : 32'd1);
            tick();
        end
        idle();
        bus.id_rs = 5'd3;
        #1;
        chk("sat_clear", 32'(bus.id_stall), 32'd0);
        chk("sat_unf_pre", 32'(bus.sb_unf), 32'd0);
        wb(5'd3, 32'hDEAD);
        tick();
        idle();
        bus.id_rs = 5'd3;
        #1;
        chk("sat_unf", 32'(bus.sb_unf), 32'd1);
        chk("sat_unf_write", bus.id_rs_data, 32'hDEAD);

        // Mid-operation reset with writers pending
        do_reset();
        wb(5'd4, 32'h55);
        tick();
        idle();
        issue(5'd4);
        tick();
        issue(5'd4);
        tick();
        idle();
        bus.id_rs = 5'd4;
        #1;
        chk("mid_busy", 32'(bus.id_stall), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.id_rs = 5'd4;
        #1;
        chk("mid_stall", 32'(bus.id_stall), 32'd0);
        chk("mid_rd", bus.id_rs_data, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            reset            = ($urandom_range(0, 59) != 0);
            bus.wb_reg_write = 1'($urandom_range(0, 1));
            bus.wb_rd        = 5'($urandom_range(0, 7));
            bus.wb_rd_data   = $urandom;
            bus.id_rs        = 5'($urandom_range(0, 7));
            bus.id_rt        = 5'($urandom_range(0, 31));
            bus.id_issue     = ($urandom_range(0, 2) != 0);
            bus.id_issue_rd  = 5'($urandom_range(0, 7));
            check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_regfile_sb.md
# wb_regfile_sb

Write-back consumer of the MEM/WB writeback bus: a 32x32 register file whose single write port is driven by the WB stage (RegWrite, destination register, selected write-back data), with two combinational read ports feeding the ID stage. A per-register scoreboard counts in-flight writers issued from ID and retired at WB, producing the ID-stage stall. The block sits between the WB mux output and the ID/EX register.

## Interface
Parameters:
- NREG, 32, number of architectural registers (index width 5)
- XLEN, 32, data width
- SBW, 2, scoreboard counter width per register (max 3 in flight)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- WB_REG_WRITE  in  1  WB[1] RegWrite from MEM/WB
- WB_RD  in  5  destination register from MEM/WB
- WB_RD_DATA  in  32  write-back data from the WB mux
- ID_RS  in  5  read index A
- ID_RT  in  5  read index B
- ID_RS_DATA  out  32  read data A
- ID_RT_DATA  out  32  read data B
- ID_ISSUE  in  1  ID issues an instruction this cycle
- ID_ISSUE_RD  in  5  destination of issued instruction (0 = no writer)
- ID_STALL  out  1  combinational; ID must hold
- SB_OVF  out  1  sticky: issue to a saturated counter
- SB_UNF  out  1  sticky: retire from a zero counter

## Operation
- Write: on edge with RESET=1, WB_REG_WRITE=1, WB_RD!=0 → reg[WB_RD] <= WB_RD_DATA. Writes to $0 discarded; reg[0] reads 0 always.
- Read: ID_xx_DATA = (index==0) ? 0 : reg[index], plus bypass (see Configuration).
- Issue accept: acc = ID_ISSUE & ~ID_STALL & (ID_ISSUE_RD!=0). Issue while stalled is ignored (no count change).
- Retire: ret = WB_REG_WRITE & (WB_RD!=0).
- Counter update per register r: +1 if acc targets r, −1 if ret targets r; both on same r → unchanged, no flag.
- Saturation: acc alone on cnt==3 → cnt held, SB_OVF<=1. ret alone on cnt==0 → cnt held, SB_UNF<=1 (write still performed). Flags stay set until reset.
- busy(r): r!=0 and cnt[r]>0, except with bypass enabled, where a register with cnt[r]==1 being retired this cycle is not busy.
- ID_STALL = busy(ID_RS) | busy(ID_RT). ID_ISSUE_RD is not checked (WAW allowed; counters handle multiple writers).

## Timing
- Reset (RESET=0 at edge): all reg[] = 0, all cnt = 0, SB_OVF = SB_UNF = 0. Consequently ID_STALL = 0, read data = 0 after reset.
- RESET has priority over write, issue and retire in the same cycle; mid-operation reset discards all in-flight counts.
- Write latency: data written at edge N visible on read ports from cycle N+1 without bypass; in cycle N itself with bypass.
- Issue counted at edge of its cycle; ID_STALL for a dependent reader rises the following cycle.
- Retire decrement at edge; without bypass, stall drops one cycle after the WB cycle.
- ID_STALL and read data purely combinational from current state and inputs; no output registers.

## Configuration
- WB_REGFILE_BYPASS_EN defined: when ret and WB_RD equals a nonzero read index, that port returns WB_RD_DATA in the same cycle; busy() excludes the retiring last writer as above.
- Undefined: read ports return stored contents only; busy(r) = cnt[r]>0; one extra stall cycle per RAW dependency resolved at WB.

## Test plan
- Reset: hold RESET=0 two cycles with WB_REG_WRITE=1, WB_RD=5, data=32'hFFFF → after release ID_RS=5 reads 0, ID_STALL=0, flags 0.
- Write/read and $0: WB write 32'd2 to r10, then 32'd7 to r0 → ID_RS=10 reads 2, ID_RT=0 reads 0; with bypass r10 reads 2 in the write cycle, without bypass old value 0.
- RAW stall: issue rd=10, then ID_RS=10 → ID_STALL=1 until WB retires r10; release in WB cycle (bypass) or the cycle after (no bypass), data = WB_RD_DATA.
- Simultaneous: cnt[8]=1, same cycle issue rd=8 and WB retire r8 → cnt stays 1, ID_RS=8 stalls next cycle; issue while ID_STALL=1 leaves counters unchanged.
- Saturation: four accepted issues to r3 with no retire → SB_OVF=1, cnt[3]=3; three retires clear stall on r3; a fourth retire sets SB_UNF=1.
- Mid-operation reset: two writers pending on r4, pulse RESET=0 one cycle → ID_STALL=0 for ID_RS=4, r4 reads 0.
